decode_e_reg: RTL and testbench

//  Y86-64 pipeline decode stage plus the D->E pipeline register. Consumes the d_* outputs of d_reg.

---
 rtl/y86_pkg.sv | 75 +++++++
 rtl/regfile_y86.sv | 39 +++
 rtl/decode_e_reg.sv | 121 ++++++++++++
 tb/tb_decode_e_reg.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// rtl/y86_pkg.sv - Y86-64 shared constants, E-register record and forwarding helper
// Contents: icode constants IHALT..IPOPQ, stat codes, register ids RNONE/RSP,
//   eReg_t (decode->execute pipeline record), eBubble(), fwdSel().
package y86_pkg;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [2:0] SAOK = 3'd1;
  localparam logic [2:0] SADR = 3'd2;
  localparam logic [2:0] SINS = 3'd3;
  localparam logic [2:0] SHLT = 3'd4;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } eReg_t;

  function automatic eReg_t eBubble();
    eReg_t b;
    b.stat  = SAOK;
    b.icode = INOP;
    b.ifun  = 4'h0;
    b.valC  = 64'd0;
    b.valA  = 64'd0;
    b.valB  = 64'd0;
    b.dstE  = RNONE;
    b.dstM  = RNONE;
    b.srcA  = RNONE;
    b.srcB  = RNONE;
    return b;
  endfunction

  // Youngest producer wins; RNONE is excluded so an unused source never picks up
  // a stage that also has no destination.
  function automatic logic [63:0] fwdSel(
    input logic [3:0]  src,
    input logic [3:0]  eDstE, input logic [63:0] eValE,
    input logic [3:0]  mDstM, input logic [63:0] mValM,
    input logic [3:0]  mDstE, input logic [63:0] mValE,
    input logic [3:0]  wDstM, input logic [63:0] wValM,
    input logic [3:0]  wDstE, input logic [63:0] wValE,
    input logic [63:0] rfVal
  );
    if (src == RNONE)      return rfVal;
    else if (src == eDstE) return eValE;
    else if (src == mDstM) return mValM;
    else if (src == mDstE) return mValE;
    else if (src == wDstM) return wValM;
    else if (src == wDstE) return wValE;
    else                   return rfVal;
  endfunction

endpackage

// File: rtl/regfile_y86.sv
// rtl/regfile_y86.sv - Y86-64 register file, 15x64, 2 async reads, 2 writes
// Ports: clk, rst_n (async, clears all registers);
//   srcA/srcB -> rdDataA/rdDataB (combinational, RNONE reads 0);
//   wrAddrE/wrDataE and wrAddrM/wrDataM written at posedge clk, RNONE ignored,
//   M port wins when both address the same register.
module regfile_y86
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  srcA,
  input  logic [3:0]  srcB,
  output logic [63:0] rdDataA,
  output logic [63:0] rdDataB,
  input  logic [3:0]  wrAddrE,
  input  logic [63:0] wrDataE,
  input  logic [3:0]  wrAddrM,
  input  logic [63:0] wrDataM
);

  logic [63:0] regs [0:14];

  // No write-through: a same-cycle reader gets the new value from W forwarding.
  assign rdDataA = (srcA == RNONE) ? 64'd0 : regs[srcA];
  assign rdDataB = (srcB == RNONE) ? 64'd0 : regs[srcB];

  // RNONE (15) never equals an index 0..14, so it drops out of the compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 15; i++) regs[i] <= 64'd0;
    end else begin
      for (int i = 0; i < 15; i++) begin
        if (wrAddrM == 4'(i))      regs[i] <= wrDataM;
        else if (wrAddrE == 4'(i)) regs[i] <= wrDataE;
      end
    end
  end

endmodule

// File: rtl/decode_e_reg.sv
// rtl/decode_e_reg.sv - Y86-64 decode stage, forwarding and D->E pipeline register
// Ports: clk, rst_n (async); E_stall/E_bubble control the E register;
//   d_* decode inputs; e_/M_/m_/W_ forwarding sources (W also writes the regfile);
//   d_srcA/d_srcB combinational to hazard control; E_* registered outputs.
module decode_e_reg
  import y86_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        E_stall,
  input  logic        E_bubble,
  input  logic [2:0]  d_stat,
  input  logic [3:0]  d_icode,
  input  logic [3:0]  d_ifun,
  input  logic [3:0]  d_rA,
  input  logic [3:0]  d_rB,
  input  logic [63:0] d_valC,
  input  logic [63:0] d_valP,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [2:0]  E_stat,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [3:0]  E_srcA,
  output logic [3:0]  E_srcB
);

  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] rfA, rfB;
  eReg_t       eNext, eReg;

  always_comb begin
    srcA = RNONE;
    srcB = RNONE;
    dstE = RNONE;
    dstM = RNONE;
    case (d_icode)
      // cmovXX always names rB; the execute stage squashes it when the condition fails.
      IRRMOVQ: begin srcA = d_rA; dstE = d_rB; end
      IIRMOVQ: dstE = d_rB;
      IRMMOVQ: begin srcA = d_rA; srcB = d_rB; end
      IMRMOVQ: begin srcB = d_rB; dstM = d_rA; end
      IOPQ:    begin srcA = d_rA; srcB = d_rB; dstE = d_rB; end
      ICALL:   begin srcB = RSP;  dstE = RSP; end
      IRET:    begin srcA = RSP;  srcB = RSP;  dstE = RSP; end
      IPUSHQ:  begin srcA = d_rA; srcB = RSP;  dstE = RSP; end
      IPOPQ:   begin srcA = RSP;  srcB = RSP;  dstE = RSP; dstM = d_rA; end
      default: ;
    endcase
  end

  assign d_srcA = srcA;
  assign d_srcB = srcB;

  regfile_y86 uRegfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .srcA    (srcA),
    .srcB    (srcB),
    .rdDataA (rfA),
    .rdDataB (rfB),
    .wrAddrE (W_dstE),
    .wrDataE (W_valE),
    .wrAddrM (W_dstM),
    .wrDataM (W_valM)
  );

  always_comb begin
    eNext       = eBubble();
    eNext.stat  = d_stat;
    eNext.icode = d_icode;
    eNext.ifun  = d_ifun;
    eNext.valC  = d_valC;
    eNext.dstE  = dstE;
    eNext.dstM  = dstM;
    eNext.srcA  = srcA;
    eNext.srcB  = srcB;
    // call and jXX carry the return/fall-through address in valA.
    if (d_icode == ICALL || d_icode == IJXX)
      eNext.valA = d_valP;
    else
      eNext.valA = fwdSel(srcA, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                          W_dstM, W_valM, W_dstE, W_valE, rfA);
    eNext.valB = fwdSel(srcB, e_dstE, e_valE, M_dstM, m_valM, M_dstE, M_valE,
                        W_dstM, W_valM, W_dstE, W_valE, rfB);
  end

  // Bubble outranks stall so hazard control can squash a stalled slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        eReg <= eBubble();
    else if (E_bubble) eReg <= eBubble();
    else if (!E_stall) eReg <= eNext;
  end

  assign E_stat  = eReg.stat;
  assign E_icode = eReg.icode;
  assign E_ifun  = eReg.ifun;
  assign E_valC  = eReg.valC;
  assign E_valA  = eReg.valA;
  assign E_valB  = eReg.valB;
  assign E_dstE  = eReg.dstE;
  assign E_dstM  = eReg.dstM;
  assign E_srcA  = eReg.srcA;
  assign E_srcB  = eReg.srcB;

endmodule

// File: tb/tb_decode_e_reg.sv
// tb/tb_decode_e_reg.sv - directed scoreboard bench for decode_e_reg
module tb_decode_e_reg;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valC;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
    logic [3:0]  srcA;
    logic [3:0]  srcB;
  } eExp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        E_stall, E_bubble;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_rA, d_rB;
  logic [63:0] d_valC, d_valP;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [2:0]  E_stat;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM, E_srcA, E_srcB;
  logic [63:0] E_valC, E_valA, E_valB;

  int checks = 0;
  int failures = 0;
  eExp_t expQ[$];
  string tagQ[$];

  always #5 clk = ~clk;

  decode_e_reg dut (
    .clk(clk), .rst_n(rst_n), .E_stall(E_stall), .E_bubble(E_bubble),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_rA(d_rA), .d_rB(d_rB),
    .d_valC(d_valC), .d_valP(d_valP),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstE(M_dstE), .M_valE(M_valE),
    .M_dstM(M_dstM), .m_valM(m_valM), .W_dstE(W_dstE), .W_valE(W_valE),
    .W_dstM(W_dstM), .W_valM(W_valM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
    .E_valC(E_valC), .E_valA(E_valA), .E_valB(E_valB),
    .E_dstE(E_dstE), .E_dstM(E_dstM), .E_srcA(E_srcA), .E_srcB(E_srcB)
  );

  function automatic eExp_t mk(logic [2:0] st, logic [3:0] ic, logic [3:0] fn,
                               logic [63:0] vc, logic [63:0] va, logic [63:0] vb,
                               logic [3:0] de, logic [3:0] dm, logic [3:0] sa, logic [3:0] sb);
    eExp_t x;
    x = '{st, ic, fn, vc, va, vb, de, dm, sa, sb};
    return x;
  endfunction

  function automatic eExp_t nopExp();
    return mk(3'd1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'hF, 4'hF);
  endfunction

  function automatic eExp_t observed();
    eExp_t x;
    x = '{E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB, E_dstE, E_dstM, E_srcA, E_srcB};
    return x;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic push(input string tag, input eExp_t e);
    expQ.push_back(e);
    tagQ.push_back(tag);
  endtask

  // One clock edge, then compare the E register against the oldest expectation.
  task automatic cycle();
    eExp_t e, o;
    string t;
    @(posedge clk);
    #1;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=empty expected=entry");
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      o = observed();
      assert (o === e) else begin
        failures++;
        $error("FAIL %s observed=%h expected=%h", t, o, e);
      end
    end
  endtask

  task automatic setD(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] rA,
                      input logic [3:0] rB, input logic [63:0] vc, input logic [63:0] vp);
    d_stat = st; d_icode = ic; d_ifun = 4'h0; d_rA = rA; d_rB = rB;
    d_valC = vc; d_valP = vp;
  endtask

  task automatic clrFwd();
    e_dstE = 4'hF; M_dstE = 4'hF; M_dstM = 4'hF; W_dstE = 4'hF; W_dstM = 4'hF;
    e_valE = 64'd0; M_valE = 64'd0; m_valM = 64'd0; W_valE = 64'd0; W_valM = 64'd0;
  endtask

  initial begin
    E_stall = 1'b0;
    E_bubble = 1'b0;
    clrFwd();
    setD(3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    checks++;
    assert (observed() === nopExp()) else begin
      failures++;
      $error("FAIL reset_state observed=%h expected=%h", observed(), nopExp());
    end
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // irmovq $100, %rdx
    setD(3'd1, 4'h3, 4'hF, 4'h2, 64'd100, 64'd10);
    push("irmovq", mk(3'd1, 4'h3, 4'h0, 64'd100, 64'd0, 64'd0, 4'h2, 4'hF, 4'hF, 4'hF));
    cycle();

    // OPq rA=3 rB=5: e beats M for A, W supplies B
    setD(3'd1, 4'h6, 4'h3, 4'h5, 64'd0, 64'h20);
    e_dstE = 4'h3; e_valE = 64'd7;
    M_dstE = 4'h3; M_valE = 64'd8;
    W_dstE = 4'h5; W_valE = 64'd9;
    #1;
    chk("d_srcA_opq", 64'(d_srcA), 64'h3);
    chk("d_srcB_opq", 64'(d_srcB), 64'h5);
    push("fwd_e_over_m", mk(3'd1, 4'h6, 4'h0, 64'd0, 64'd7, 64'd9, 4'h5, 4'hF, 4'h3, 4'h5));
    cycle();
    e_dstE = 4'hF;
    push("fwd_m_dstE", mk(3'd1, 4'h6, 4'h0, 64'd0, 64'd8, 64'd9, 4'h5, 4'hF, 4'h3, 4'h5));
    cycle();
    // M_dstM beats M_dstE, W_dstM beats W_dstE; regfile[5] gets 12 (M port wins)
    M_dstM = 4'h3; m_valM = 64'd11;
    W_dstM = 4'h5; W_valM = 64'd12;
    push("fwd_m_dstM_w_dstM", mk(3'd1, 4'h6, 4'h0, 64'd0, 64'd11, 64'd12, 4'h5, 4'hF, 4'h3, 4'h5));
    cycle();
    clrFwd();
    push("rf_read_after_collision", mk(3'd1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd12, 4'h5, 4'hF, 4'h3, 4'h5));
    cycle();

    // Writeback into regfile[6], then read it back through rrmovq
    setD(3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    W_dstE = 4'h6; W_valE = 64'd55;
    push("nop_during_wb", nopExp());
    cycle();
    clrFwd();
    setD(3'd1, 4'h2, 4'h6, 4'h7, 64'd0, 64'd0);
    push("rrmovq_wb55", mk(3'd1, 4'h2, 4'h0, 64'd0, 64'd55, 64'd0, 4'h7, 4'hF, 4'h6, 4'hF));
    cycle();
    setD(3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    W_dstE = 4'h6; W_valE = 64'd1; W_dstM = 4'h6; W_valM = 64'd2;
    push("nop_collision", nopExp());
    cycle();
    clrFwd();
    setD(3'd1, 4'h2, 4'h6, 4'h7, 64'd0, 64'd0);
    push("rrmovq_collision", mk(3'd1, 4'h2, 4'h0, 64'd0, 64'd2, 64'd0, 4'h7, 4'hF, 4'h6, 4'hF));
    cycle();

    // Load %rsp, then call and popq
    setD(3'd1, 4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    W_dstE = 4'h4; W_valE = 64'h1000;
    push("nop_rsp_wb", nopExp());
    cycle();
    clrFwd();
    setD(3'd1, 4'h8, 4'hF, 4'hF, 64'h200, 64'd64);
    push("call", mk(3'd1, 4'h8, 4'h0, 64'h200, 64'd64, 64'h1000, 4'h4, 4'hF, 4'hF, 4'h4));
    cycle();
    setD(3'd1, 4'hB, 4'h0, 4'hF, 64'd0, 64'h30);
    push("popq", mk(3'd1, 4'hB, 4'h0, 64'd0, 64'h1000, 64'h1000, 4'h4, 4'h0, 4'h4, 4'h4));
    cycle();

    // Stall holds popq, bubble beats stall, then a fresh load (stat passed through)
    E_stall = 1'b1;
    setD(3'd4, 4'h3, 4'hF, 4'h9, 64'h77, 64'd0);
    push("stall1", mk(3'd1, 4'hB, 4'h0, 64'd0, 64'h1000, 64'h1000, 4'h4, 4'h0, 4'h4, 4'h4));
    cycle();
    push("stall2", mk(3'd1, 4'hB, 4'h0, 64'd0, 64'h1000, 64'h1000, 4'h4, 4'h0, 4'h4, 4'h4));
    cycle();
    E_bubble = 1'b1;
    push("bubble_over_stall", nopExp());
    cycle();
    E_stall = 1'b0;
    E_bubble = 1'b0;
    push("load_after_bubble", mk(3'd4, 4'h3, 4'h0, 64'h77, 64'd0, 64'd0, 4'h9, 4'hF, 4'hF, 4'hF));
    cycle();

    // Asynchronous reset mid-cycle takes effect before any edge
    #3 rst_n = 1'b0;
    #1;
    chk("async_rst_icode", 64'(E_icode), 64'h1);
    chk("async_rst_stat", 64'(E_stat), 64'h1);
    chk("async_rst_dstE", 64'(E_dstE), 64'hF);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Every register reads 0 after reset (4, 5, 6 held nonzero values)
    for (int r = 0; r < 15; r++) begin
      setD(3'd1, 4'h2, 4'(r), 4'hF, 64'd0, 64'd0);
      push($sformatf("rf_zero_r%0d", r),
           mk(3'd1, 4'h2, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF, 4'hF, 4'(r), 4'hF));
      cycle();
    end

    chk("scoreboard_drained", 64'(expQ.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
